mii_rx_frame_gen: RTL and testbench

//  PHY-side MII receive-path frame generator: turns a byte stream into MII receive nibbles
//  (mrxd/mrx_dv/mrx_err/crs) that feed the Ethernet MAC's receive pads.

---
 rtl/mii_rx_frame_gen_if.sv | 24 ++
 rtl/mii_rx_frame_gen.sv | 203 ++++++++++++++++++++
 tb/tb_mii_rx_frame_gen.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mii_rx_frame_gen_if.sv
// Upstream byte stream feeding the MII receive frame generator.
interface mii_rx_frame_gen_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_err;
  logic       s_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output s_err,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  s_err,
    output s_ready
  );
endinterface

// File: rtl/mii_rx_frame_gen.sv
// PHY-side MII receive frame generator: wraps an upstream byte stream in preamble, SFD,
// optional CRC-32 FCS and inter-frame gap, and emits it as MII receive nibbles.
module mii_rx_frame_gen #(
  parameter int unsigned PREAMBLE_NIBBLES = 15,
  parameter int unsigned IFG_NIBBLES      = 24,
  parameter bit          APPEND_CRC       = 1'b1
) (
  input  logic              mrx_clk,
  input  logic              rst_n,
  mii_rx_frame_gen_if.slave up,
  output logic [3:0]        mrxd,
  output logic              mrx_dv,
  output logic              mrx_err,
  output logic              crs,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int unsigned PreIfgMax = (PREAMBLE_NIBBLES > IFG_NIBBLES) ? PREAMBLE_NIBBLES
                                                                        : IFG_NIBBLES;
  localparam int unsigned CntMax    = (PreIfgMax > 8) ? PreIfgMax : 8;
  localparam int unsigned CntW      = $clog2(CntMax);
  localparam logic [CntW-1:0] PreLast = CntW'(PREAMBLE_NIBBLES - 1);
  localparam logic [CntW-1:0] IfgLast = CntW'(IFG_NIBBLES - 1);
  localparam logic [CntW-1:0] FcsLast = CntW'(7);
  localparam logic [31:0]     CrcPoly = 32'hEDB88320;

  typedef enum logic [2:0] {
    StIdle, StPre, StSfd, StDlo, StDhi, StFcs, StAbort, StIfg
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      held_data_q, held_data_d;
  logic            held_last_q, held_last_d;
  logic            held_err_q, held_err_d;
  logic [31:0]     crc_q, crc_d;
  logic [31:0]     crc_inv;
  logic [4:0]      fcs_base;
  logic            accept;
  logic [3:0]      mrxd_d;
  logic            dv_d, err_d, busy_d, done_d, under_d;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  // Ready in IDLE, and in DHI while more bytes of the current frame are expected.
  assign up.s_ready = (state_q == StIdle) || ((state_q == StDhi) && !held_last_q);
  assign accept     = up.s_valid && up.s_ready;

  // Next-state, counter, holding register and CRC update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    held_data_d = held_data_q;
    held_last_d = held_last_q;
    held_err_d  = held_err_q;
    crc_d       = crc_q;
    if (accept) begin
      held_data_d = up.s_data;
      held_last_d = up.s_last;
      held_err_d  = up.s_err;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          crc_d   = '1;
          cnt_d   = '0;
          state_d = StPre;
        end
      end
      StPre: begin
        if (cnt_q == PreLast) begin
          cnt_d   = '0;
          state_d = StSfd;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSfd: state_d = StDlo;
      StDlo: state_d = StDhi;
      StDhi: begin
        crc_d = crc_byte(crc_q, held_data_q);
        cnt_d = '0;
        if (held_last_q) begin
          state_d = APPEND_CRC ? StFcs : StIfg;
        end else if (accept) begin
          state_d = StDlo;
        end else begin
          state_d = StAbort;
        end
      end
      StFcs: begin
        if (cnt_q == FcsLast) begin
          cnt_d   = '0;
          state_d = StIfg;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAbort: begin
        cnt_d   = '0;
        state_d = StIfg;
      end
      StIfg: begin
        if (cnt_q == IfgLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    mrxd_d   = 4'h0;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    under_d  = 1'b0;
    busy_d   = (state_d != StIdle);
    crc_inv  = ~crc_d;
    fcs_base = {cnt_d[2:0], 2'b00};
    unique case (state_d)
      StPre: begin
        dv_d   = 1'b1;
        mrxd_d = 4'h5;
      end
      StSfd: begin
        dv_d   = 1'b1;
        mrxd_d = 4'hD;
      end
      StDlo: begin
        dv_d   = 1'b1;
        err_d  = held_err_d;
        mrxd_d = held_data_d[3:0];
      end
      StDhi: begin
        dv_d   = 1'b1;
        err_d  = held_err_d;
        mrxd_d = held_data_d[7:4];
        done_d = held_last_d && !APPEND_CRC;
      end
      StFcs: begin
        dv_d   = 1'b1;
        mrxd_d = crc_inv[fcs_base +: 4];
        done_d = (cnt_d == FcsLast);
      end
      StAbort: begin
        dv_d    = 1'b1;
        err_d   = 1'b1;
        done_d  = 1'b1;
        under_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge mrx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      held_data_q <= '0;
      held_last_q <= 1'b0;
      held_err_q  <= 1'b0;
      crc_q       <= '0;
      mrxd        <= 4'h0;
      mrx_dv      <= 1'b0;
      mrx_err     <= 1'b0;
      crs         <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_data_q <= held_data_d;
      held_last_q <= held_last_d;
      held_err_q  <= held_err_d;
      crc_q       <= crc_d;
      mrxd        <= mrxd_d;
      mrx_dv      <= dv_d;
      mrx_err     <= err_d;
      crs         <= dv_d;
      busy        <= busy_d;
      frame_done  <= done_d;
      underrun    <= under_d;
    end
  end

endmodule

// File: tb/tb_mii_rx_frame_gen.sv
// Bench for mii_rx_frame_gen: one instance without FCS, one with FCS, sharing a byte driver.
module tb_mii_rx_frame_gen;

  localparam int Pre = 15;
  localparam int Ifg = 24;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       crs;
    logic       dv;
    logic       err;
    logic       under;
    logic       done;
    logic [3:0] nib;
  } obs_t;

  typedef struct packed {
    logic        sel;
    int          n;
    logic [71:0] data;
    logic [8:0]  emask;
    int          drop;
    int          exp_dv;
    int          exp_err;
    int          exp_under;
    logic        chk_fcs;
    logic [31:0] exp_fcs;
  } vec_t;

  logic       mrx_clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       drv_valid;
  logic [7:0] drv_data;
  logic       drv_last;
  logic       drv_err;

  logic [3:0] mrxd0, mrxd1;
  logic       dv0, dv1, err0, err1, crs0, crs1, busy0, busy1;
  logic       done0, done1, under0, under1;
  obs_t       obs0, obs1, obs;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t cap_q[$];
  logic cap_ok;

  mii_rx_frame_gen_if if0 ();
  mii_rx_frame_gen_if if1 ();

  assign if0.s_valid = drv_valid & ~sel;
  assign if1.s_valid = drv_valid & sel;
  assign if0.s_data  = drv_data;
  assign if1.s_data  = drv_data;
  assign if0.s_last  = drv_last;
  assign if1.s_last  = drv_last;
  assign if0.s_err   = drv_err;
  assign if1.s_err   = drv_err;

  mii_rx_frame_gen #(
    .PREAMBLE_NIBBLES(Pre),
    .IFG_NIBBLES     (Ifg),
    .APPEND_CRC      (1'b0)
  ) u_dut0 (
    .mrx_clk   (mrx_clk),
    .rst_n     (rst_n),
    .up        (if0),
    .mrxd      (mrxd0),
    .mrx_dv    (dv0),
    .mrx_err   (err0),
    .crs       (crs0),
    .busy      (busy0),
    .frame_done(done0),
    .underrun  (under0)
  );

  mii_rx_frame_gen #(
    .PREAMBLE_NIBBLES(Pre),
    .IFG_NIBBLES     (Ifg),
    .APPEND_CRC      (1'b1)
  ) u_dut1 (
    .mrx_clk   (mrx_clk),
    .rst_n     (rst_n),
    .up        (if1),
    .mrxd      (mrxd1),
    .mrx_dv    (dv1),
    .mrx_err   (err1),
    .crs       (crs1),
    .busy      (busy1),
    .frame_done(done1),
    .underrun  (under1)
  );

  always #5 mrx_clk = ~mrx_clk;

  always_comb begin
    obs0 = {if0.s_ready, busy0, crs0, dv0, err0, under0, done0, mrxd0};
    obs1 = {if1.s_ready, busy1, crs1, dv1, err1, under1, done1, mrxd1};
    obs  = sel ? obs1 : obs0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic obs_t mk(input logic rdy, input logic bsy, input logic dv, input logic er,
                              input logic un, input logic dn, input logic [3:0] nib);
    return {rdy, bsy, dv, dv, er, un, dn, nib};
  endfunction

  // Bit-serial reflected CRC-32 over the whole frame; returns the transmitted FCS value.
  function automatic logic [31:0] fcs_of(input logic [7:0] d[$]);
    logic [31:0] r;
    logic        fb;
    r = '1;
    for (int i = 0; i < d.size() * 8; i++) begin
      fb = r[0] ^ d[i / 8][i % 8];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return ~r;
  endfunction

  // Appends one frame's expected per-cycle outputs, from first mrx_dv through the idle cycle
  // that follows the gap.
  function automatic void build_frame(input logic [7:0] d[$], input logic e[$], input int drop,
                                      input logic crc);
    int          n;
    int          m;
    logic [31:0] f;
    n = d.size();
    m = (drop >= 0) ? drop : n;
    for (int p = 0; p < Pre; p++) exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 4'h5));
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 4'hD));
    for (int i = 0; i < m; i++) begin
      exp_q.push_back(mk(0, 1, 1, e[i], 0, 0, d[i][3:0]));
      exp_q.push_back(mk(i != n - 1, 1, 1, e[i], 0, (i == n - 1) && !crc, d[i][7:4]));
    end
    if (m < n) begin
      exp_q.push_back(mk(0, 1, 1, 1, 1, 1, 4'h0));
    end else if (crc) begin
      f = fcs_of(d);
      for (int k = 0; k < 8; k++) exp_q.push_back(mk(0, 1, 1, 0, 0, k == 7, f[4*k +: 4]));
    end
    for (int g = 0; g < Ifg; g++) exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 4'h0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0));
  endfunction

  // ---------------- driver / monitor / checks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive(input logic [7:0] d[$], input logic e[$], input logic l[$], input int cnt);
    int t;
    for (int i = 0; i < cnt; i++) begin
      t         = 0;
      drv_valid = 1'b1;
      drv_data  = d[i];
      drv_last  = l[i];
      drv_err   = e[i];
      while (!obs.ready && t < 100) begin
        @(negedge mrx_clk);
        t++;
      end
      if (t >= 100) begin
        checks++;
        errors++;
        $display("FAIL drive byte %0d: s_ready got 0 for 100 cycles want 1", i);
        drv_valid = 1'b0;
        return;
      end
      @(negedge mrx_clk);
    end
    drv_valid = 1'b0;
  endtask

  task automatic capture(input int len);
    int t;
    t      = 0;
    cap_ok = 1'b1;
    cap_q.delete();
    while (!obs.dv) begin
      @(negedge mrx_clk);
      t++;
      if (t > 200) begin
        cap_ok = 1'b0;
        return;
      end
    end
    for (int i = 0; i < len; i++) begin
      cap_q.push_back(obs);
      @(negedge mrx_clk);
    end
  endtask

  task automatic compare_stream(input string name);
    int bad;
    bad = -1;
    checks++;
    if (!cap_ok) begin
      errors++;
      $display("FAIL %s stream: mrx_dv got 0 for 200 cycles want 1", name);
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
    end
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s stream cycle %0d: got %03h want %03h (ready,busy,crs,dv,err,underrun,done,mrxd)",
               name, bad, cap_q[bad], exp_q[bad]);
    end
  endtask

  task automatic run_case(input string name, input logic s, input logic [7:0] d[$],
                          input logic e[$], input int drop);
    logic l[$];
    int   cnt;
    for (int i = 0; i < d.size(); i++) l.push_back(i == d.size() - 1);
    cnt = (drop >= 0) ? drop : d.size();
    @(negedge mrx_clk);
    sel = s;
    exp_q.delete();
    build_frame(d, e, drop, s);
    fork
      drive(d, e, l, cnt);
      capture(exp_q.size());
    join
    compare_stream(name);
  endtask

  function automatic void summarize(output int dv, output int er, output int un, output int dn,
                                    output logic [31:0] fcs);
    logic [3:0] nibs[$];
    dv  = 0;
    er  = 0;
    un  = 0;
    dn  = 0;
    fcs = '0;
    foreach (cap_q[i]) begin
      if (cap_q[i].dv) begin
        dv++;
        nibs.push_back(cap_q[i].nib);
      end
      if (cap_q[i].err) er++;
      if (cap_q[i].under) un++;
      if (cap_q[i].done) dn++;
    end
    if (nibs.size() >= 8) begin
      for (int k = 0; k < 8; k++) fcs[4*k +: 4] = nibs[nibs.size() - 8 + k];
    end
  endfunction

  // ---------------- test sequence ----------------
  vec_t        tbl[7];
  logic [7:0]  dq[$];
  logic        eq[$];
  logic        lq[$];
  int          m_dv, m_er, m_un, m_dn;
  logic [31:0] m_fcs;
  string       nm;
  int          i_done, i_next;
  int          r_n, r_drop;
  logic        r_s;
  logic [31:0] f5a;

  initial begin
    tbl[0] = '{sel: 1'b0, n: 1, data: 72'h5A, emask: 9'h0, drop: -1, exp_dv: 18, exp_err: 0,
               exp_under: 0, chk_fcs: 1'b0, exp_fcs: 32'h0};
    tbl[1] = '{sel: 1'b1, n: 9, data: 72'h39_38_37_36_35_34_33_32_31, emask: 9'h0, drop: -1,
               exp_dv: 42, exp_err: 0, exp_under: 0, chk_fcs: 1'b1, exp_fcs: 32'hCBF43926};
    tbl[2] = '{sel: 1'b1, n: 4, data: 72'h04_03_02_01, emask: 9'h0, drop: 2, exp_dv: 21,
               exp_err: 1, exp_under: 1, chk_fcs: 1'b0, exp_fcs: 32'h0};
    tbl[3] = '{sel: 1'b1, n: 5, data: 72'h50_40_30_20_10, emask: 9'b000000100, drop: -1,
               exp_dv: 34, exp_err: 2, exp_under: 0, chk_fcs: 1'b0, exp_fcs: 32'h0};
    tbl[4] = '{sel: 1'b0, n: 3, data: 72'hBE_AD_DE, emask: 9'h0, drop: -1, exp_dv: 22,
               exp_err: 0, exp_under: 0, chk_fcs: 1'b0, exp_fcs: 32'h0};
    tbl[5] = '{sel: 1'b1, n: 1, data: 72'h00, emask: 9'h0, drop: -1, exp_dv: 26, exp_err: 0,
               exp_under: 0, chk_fcs: 1'b1, exp_fcs: 32'hD202EF8D};
    tbl[6] = '{sel: 1'b0, n: 2, data: 72'h3C_C3, emask: 9'b000000011, drop: -1, exp_dv: 20,
               exp_err: 4, exp_under: 0, chk_fcs: 1'b0, exp_fcs: 32'h0};

    rst_n     = 1'b0;
    sel       = 1'b0;
    drv_valid = 1'b0;
    drv_data  = 8'h00;
    drv_last  = 1'b0;
    drv_err   = 1'b0;
    #23;
    chk("reset outputs nocrc", obs0, 11'h400);
    chk("reset outputs crc", obs1, 11'h400);
    @(negedge mrx_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge mrx_clk);

    // Directed vectors.
    for (int v = 0; v < 7; v++) begin
      dq.delete();
      eq.delete();
      for (int i = 0; i < tbl[v].n; i++) begin
        dq.push_back(tbl[v].data[8*i +: 8]);
        eq.push_back(tbl[v].emask[i]);
      end
      nm = $sformatf("vec%0d", v);
      run_case(nm, tbl[v].sel, dq, eq, tbl[v].drop);
      summarize(m_dv, m_er, m_un, m_dn, m_fcs);
      chk({nm, " dv_cycles"}, m_dv, tbl[v].exp_dv);
      chk({nm, " err_nibbles"}, m_er, tbl[v].exp_err);
      chk({nm, " underrun_pulses"}, m_un, tbl[v].exp_under);
      chk({nm, " frame_done_pulses"}, m_dn, 1);
      if (tbl[v].chk_fcs) chk({nm, " fcs"}, m_fcs, tbl[v].exp_fcs);
    end

    // Back-to-back 2-byte frames with s_valid held high.
    @(negedge mrx_clk);
    sel = 1'b1;
    exp_q.delete();
    dq.delete();
    eq.delete();
    dq.push_back(8'h11);
    dq.push_back(8'h22);
    eq.push_back(1'b0);
    eq.push_back(1'b0);
    build_frame(dq, eq, -1, 1'b1);
    dq.delete();
    dq.push_back(8'h33);
    dq.push_back(8'h44);
    build_frame(dq, eq, -1, 1'b1);
    dq.delete();
    eq.delete();
    lq.delete();
    dq.push_back(8'h11);
    dq.push_back(8'h22);
    dq.push_back(8'h33);
    dq.push_back(8'h44);
    for (int i = 0; i < 4; i++) begin
      eq.push_back(1'b0);
      lq.push_back(i[0]);
    end
    fork
      drive(dq, eq, lq, 4);
      capture(exp_q.size());
    join
    compare_stream("b2b");
    i_done = -1;
    i_next = -1;
    foreach (cap_q[i]) begin
      if (i_done < 0 && cap_q[i].done) i_done = i;
      else if (i_done >= 0 && i_next < 0 && cap_q[i].dv && !cap_q[i-1].dv) i_next = i;
    end
    chk("b2b done_to_next_dv", i_next - i_done, 26);

    // Asynchronous reset during FCS nibble 3, then a clean restart.
    @(negedge mrx_clk);
    sel       = 1'b1;
    drv_valid = 1'b1;
    drv_data  = 8'h5A;
    drv_last  = 1'b1;
    drv_err   = 1'b0;
    @(negedge mrx_clk);
    drv_valid = 1'b0;
    chk("rst first dv", obs.dv, 1);
    repeat (20) @(negedge mrx_clk);
    dq.delete();
    dq.push_back(8'h5A);
    f5a = fcs_of(dq);
    chk("rst fcs nibble3 dv", obs.dv, 1);
    chk("rst fcs nibble3", obs.nib, f5a[11:8]);
    #1 rst_n = 1'b0;
    #1;
    chk("rst async crc", obs1, 11'h400);
    chk("rst async nocrc", obs0, 11'h400);
    @(negedge mrx_clk);
    @(negedge mrx_clk);
    rst_n = 1'b1;
    eq.delete();
    eq.push_back(1'b0);
    run_case("post_rst crc", 1'b1, dq, eq, -1);
    run_case("post_rst nocrc", 1'b0, dq, eq, -1);
    summarize(m_dv, m_er, m_un, m_dn, m_fcs);
    chk("post_rst nocrc dv_cycles", m_dv, 18);

    // Randomised frames against the model.
    for (int r = 0; r < 24; r++) begin
      dq.delete();
      eq.delete();
      r_s = 1'($urandom_range(0, 1));
      r_n = int'($urandom_range(1, 8));
      for (int i = 0; i < r_n; i++) begin
        dq.push_back(8'($urandom));
        eq.push_back($urandom_range(0, 7) == 0);
      end
      r_drop = -1;
      if (r_n >= 2 && $urandom_range(0, 3) == 0) r_drop = int'($urandom_range(1, r_n - 1));
      repeat ($urandom_range(0, 3)) @(negedge mrx_clk);
      run_case($sformatf("rand%0d", r), r_s, dq, eq, r_drop);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
